// File: rtl/nor_chain_pulse_tester_if.sv
// rtl/nor_chain_pulse_tester_if.sv - control/result bus between test controller and pulse tester
//
// Purpose: carries the run request with its operands towards the tester and the
// run status and measurement back to the controller.
// Signals:
//   start        controller -> tester  one-cycle run request
//   pulse_width  controller -> tester  high-phase length in clk cycles
//   gap_width    controller -> tester  low-phase length in clk cycles
//   pulse_count  controller -> tester  number of pulses to launch
//   busy         tester -> controller  run in progress
//   done         tester -> controller  sticky completion flag
//   rise_count   tester -> controller  pulses seen at the chain output
// Modports: master (controller side), slave (tester side).

interface nor_chain_pulse_tester_if #(
    parameter int PW_W  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PW_W-1:0]  pulse_width;
    logic [PW_W-1:0]  gap_width;
    logic [CNT_W-1:0] pulse_count;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rise_count;

    modport master (
        output start, pulse_width, gap_width, pulse_count,
        input  busy, done, rise_count
    );

    modport slave (
        input  start, pulse_width, gap_width, pulse_count,
        output busy, done, rise_count
    );
endinterface

// File: rtl/NOR2_X1.sv
// rtl/NOR2_X1.sv - behavioural model of the NOR2_X1 standard cell
//
// Purpose: two-input NOR used as the delay element of the evaluation chain.
// Ports:
//   A1  in   first NOR input
//   A2  in   second NOR input
//   ZN  out  ~(A1 | A2)

module NOR2_X1 (
    input  logic A1,
    input  logic A2,
    output logic ZN
);
    assign ZN = ~(A1 | A2);
endmodule

// File: rtl/nor_chain_pulse_tester.sv
// rtl/nor_chain_pulse_tester.sv - NOR2_X1 delay chain with pulse-train launcher and edge counter
//
// Purpose: launches a programmable pulse train into a STAGES-long chain of
// NOR2_X1 inverters and counts how many rising edges survive to the output.
// Ports:
//   clk          in   single rising-edge clock
//   rst          in   asynchronous active-high reset
//   ctrl         slave side of nor_chain_pulse_tester_if (start/operands in,
//                busy/done/rise_count out); its PW_W/CNT_W must match ours
//   chain_in_o   out  registered chain input (stage 0 A-pin)
//   chain_out_o  out  raw chain output, inverted when STAGES is odd

module nor_chain_pulse_tester #(
    parameter int STAGES     = 26,
    parameter int SWAP_START = 11,
    parameter int PW_W       = 8,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    nor_chain_pulse_tester_if.slave   ctrl,
    output logic                      chain_in_o,
    output logic                      chain_out_o
);
    localparam int ST_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam bit INVERT = (STAGES % 2) == 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic [PW_W-1:0]  pw_q, pw_d;
    logic [PW_W-1:0]  gw_q, gw_d;
    logic [PW_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [ST_W-1:0]  settle_q, settle_d;
    logic             chain_in_q, chain_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             meas_in;
    logic             sync1_q, sync2_q, prev_q;
    logic             rise_edge;

    // ------------------------------------------------------------------
    // Delay chain: each stage is a NOR with its spare input grounded.
    // Pin usage alternates A1/A2 from SWAP_START on so both input arcs
    // of the cell get exercised by the same pulse.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic stage_a;
            logic stage_zn;

            if (i == 0) begin : g_head
                assign stage_a = chain_in_q;
            end else begin : g_link
                assign stage_a = g_stage[i-1].stage_zn;
            end

            if ((i >= SWAP_START) && (((i - SWAP_START) % 2) == 1)) begin : g_a2
                (* keep = "true", dont_touch = "true" *)
                NOR2_X1 u_nor (
                    .A1 (1'b0),
                    .A2 (stage_a),
                    .ZN (stage_zn)
                );
            end else begin : g_a1
                (* keep = "true", dont_touch = "true" *)
                NOR2_X1 u_nor (
                    .A1 (stage_a),
                    .A2 (1'b0),
                    .ZN (stage_zn)
                );
            end
        end
    endgenerate

    assign chain_out_o = g_stage[STAGES-1].stage_zn;

    // Undo the odd-length inversion so the counter always sees launch polarity.
    assign meas_in   = chain_out_o ^ INVERT;
    assign rise_edge = sync2_q & ~prev_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pw_q       <= '0;
            gw_q       <= '0;
            phase_q    <= '0;
            rem_q      <= '0;
            rise_q     <= '0;
            settle_q   <= '0;
            chain_in_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            gw_q       <= gw_d;
            phase_q    <= phase_d;
            rem_q      <= rem_d;
            rise_q     <= rise_d;
            settle_q   <= settle_d;
            chain_in_q <= chain_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sync1_q    <= meas_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // Launcher FSM and counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pw_d     = pw_q;
        gw_d     = gw_q;
        phase_d  = phase_q;
        rem_d    = rem_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rise_d   = rise_q;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl.start) begin
                    // Zero-length phases would stall the counters; run them as one cycle.
                    pw_d     = (ctrl.pulse_width == '0) ? PW_W'(1) : ctrl.pulse_width;
                    gw_d     = (ctrl.gap_width == '0) ? PW_W'(1) : ctrl.gap_width;
                    rem_d    = ctrl.pulse_count;
                    phase_d  = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    rise_d   = '0;
                    state_d  = (ctrl.pulse_count == '0) ? S_SETTLE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_q == pw_q - PW_W'(1)) begin
                    phase_d = '0;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + PW_W'(1);
                end
            end
            S_LOW: begin
                if (phase_q == gw_q - PW_W'(1)) begin
                    phase_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? S_SETTLE : S_HIGH;
                end else begin
                    phase_d = phase_q + PW_W'(1);
                end
            end
            S_SETTLE: begin
                if (settle_q == ST_W'(SETTLE_CYC - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q + ST_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Count only inside a run; the start edge's clear above has priority.
        if ((state_q != S_IDLE) && rise_edge && (rise_q != '1)) begin
            rise_d = rise_q + CNT_W'(1);
        end

        // chain_in is registered from the next state so it lines up with HIGH.
        chain_in_d = (state_d == S_HIGH);
    end

    assign chain_in_o      = chain_in_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.done       = done_q;
    assign ctrl.rise_count = rise_q;
endmodule

// File: tb/tb_nor_chain_pulse_tester.sv
// tb/tb_nor_chain_pulse_tester.sv - self-checking bench for nor_chain_pulse_tester

module tb_nor_chain_pulse_tester;
    localparam int PW_W   = 8;
    localparam int CNT_W  = 16;
    localparam int SETTLE = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chain_in_a, chain_out_a, chain_in_b, chain_out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nor_chain_pulse_tester_if #(.PW_W(PW_W), .CNT_W(CNT_W)) bus_a ();
    nor_chain_pulse_tester_if #(.PW_W(PW_W), .CNT_W(CNT_W)) bus_b ();

    nor_chain_pulse_tester #(.STAGES(26)) dut_even (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (bus_a.slave),
        .chain_in_o  (chain_in_a),
        .chain_out_o (chain_out_a)
    );

    nor_chain_pulse_tester #(.STAGES(25)) dut_odd (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (bus_b.slave),
        .chain_in_o  (chain_in_b),
        .chain_out_o (chain_out_b)
    );

    typedef struct {
        int    pw;
        int    gw;
        int    cnt;
        int    exp_busy;
        int    exp_rise;
        string tag;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int pw, input int gw, input int cnt, input logic st);
        bus_a.pulse_width = PW_W'(pw);
        bus_a.gap_width   = PW_W'(gw);
        bus_a.pulse_count = CNT_W'(cnt);
        bus_a.start       = st;
        bus_b.pulse_width = PW_W'(pw);
        bus_b.gap_width   = PW_W'(gw);
        bus_b.pulse_count = CNT_W'(cnt);
        bus_b.start       = st;
    endtask

    // Expected chain_in waveform, one bit per cycle after the accepted start.
    task automatic run_train(input int pw, input int gw, input int cnt, input bit retrig,
                             input int exp_busy, input int exp_rise, input string tag);
        bit exp_wave[$];
        int pwe, gwe, bad_wave, bad_pol, busy_cycles;
        pwe = (pw == 0) ? 1 : pw;
        gwe = (gw == 0) ? 1 : gw;
        for (int p = 0; p < cnt; p++) begin
            for (int j = 0; j < pwe; j++) exp_wave.push_back(1'b1);
            for (int j = 0; j < gwe; j++) exp_wave.push_back(1'b0);
        end
        for (int s = 0; s < SETTLE; s++) exp_wave.push_back(1'b0);

        bad_wave    = 0;
        bad_pol     = 0;
        busy_cycles = 0;

        @(negedge clk);
        drive(pw, gw, cnt, 1'b1);
        @(negedge clk);
        drive(pw, gw, cnt, 1'b0);
        check({tag, ".done_cleared"}, int'(bus_a.done), 0);

        for (int k = 0; k < exp_wave.size(); k++) begin
            if (bus_a.busy) busy_cycles++;
            if (chain_in_a !== exp_wave[k] || bus_a.done !== 1'b0 ||
                chain_in_b !== exp_wave[k] || bus_b.busy !== 1'b1)
                bad_wave++;
            if (chain_out_a !== chain_in_a) bad_pol++;
            if (chain_out_b !== ~chain_in_b) bad_pol++;
            if (retrig && (k == 2 || k == 6))
                drive(1, 1, 9, 1'b1);
            else
                drive(pw, gw, cnt, 1'b0);
            @(negedge clk);
        end

        check({tag, ".wave_bad_cycles"}, bad_wave, 0);
        check({tag, ".polarity_bad"}, bad_pol, 0);
        check({tag, ".busy_cycles"}, busy_cycles, exp_busy);
        check({tag, ".busy_end"}, int'(bus_a.busy), 0);
        check({tag, ".done_end"}, int'(bus_a.done), 1);
        check({tag, ".rise_even"}, int'(bus_a.rise_count), exp_rise);
        check({tag, ".rise_odd"}, int'(bus_b.rise_count), exp_rise);

        repeat (3) @(negedge clk);
        check({tag, ".done_sticky"}, int'(bus_a.done & bus_b.done), 1);
        check({tag, ".idle_chain_in"}, int'(chain_in_a | chain_in_b), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pw, gw, cnt;

        vecs[0] = '{4, 4, 10, 88, 10, "T2"};
        vecs[1] = '{3, 3, 0, 8, 0, "T3"};
        vecs[2] = '{0, 0, 3, 14, 3, "T4"};
        vecs[3] = '{3, 3, 4, 32, 4, "T6"};
        vecs[4] = '{1, 7, 2, 24, 2, "V_narrow"};
        vecs[5] = '{2, 1, 5, 23, 5, "V_shortgap"};

        drive(0, 0, 0, 1'b0);
        #2 rst = 1'b1;
        #2;
        check("reset.chain_in", int'(chain_in_a), 0);
        check("reset.busy", int'(bus_a.busy), 0);
        check("reset.done", int'(bus_a.done), 0);
        check("reset.rise_count", int'(bus_a.rise_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_train(vecs[i].pw, vecs[i].gw, vecs[i].cnt, 1'b0,
                      vecs[i].exp_busy, vecs[i].exp_rise, vecs[i].tag);

        // T5: starts during the run must not touch the latched operands.
        run_train(5, 5, 2, 1'b1, 28, 2, "T5");

        // T1: asynchronous reset in the middle of a HIGH phase.
        @(negedge clk);
        drive(8, 8, 3, 1'b1);
        @(negedge clk);
        drive(8, 8, 3, 1'b0);
        repeat (4) @(negedge clk);
        check("T1.pre_chain_in", int'(chain_in_a), 1);
        check("T1.pre_rise", int'(bus_a.rise_count), 1);
        #2 rst = 1'b1;
        #1;
        check("T1.chain_in", int'(chain_in_a | chain_in_b), 0);
        check("T1.busy", int'(bus_a.busy | bus_b.busy), 0);
        check("T1.done", int'(bus_a.done | bus_b.done), 0);
        check("T1.rise", int'(bus_a.rise_count | bus_b.rise_count), 0);
        @(negedge clk);
        rst = 1'b0;
        run_train(2, 3, 3, 1'b0, 23, 3, "T1_post");

        // Randomised trains against the arithmetic model.
        for (int r = 0; r < 6; r++) begin
            pw  = int'($urandom_range(0, 6));
            gw  = int'($urandom_range(0, 6));
            cnt = int'($urandom_range(0, 5));
            run_train(pw, gw, cnt, 1'b0,
                      cnt * ((pw == 0 ? 1 : pw) + (gw == 0 ? 1 : gw)) + SETTLE,
                      cnt, $sformatf("R%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
